gap_fill_serial: RTL and testbench
==================================

GAP_FILL_SERIAL -- requirements
Module: gap_fill_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 6: word width in bits, minimum 3.
REQ-002 SHALL have parameter MAX_GAP, default 3: largest fillable zero-run length, range 1..WIDTH-2.
REQ-003 SHALL use one clock and a synchronous, active-high reset; both are listed below.
REQ-004 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous reset, active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data and gap_len are valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-008 SHALL have port in_data, input, WIDTH bits: word to process; bit WIDTH-1 is scanned first.
REQ-009 SHALL have port gap_len, input, GAP_W bits: maximum zero-run length to fill, sampled at accept; GAP_W = clog2(MAX_GAP+1).
REQ-010 SHALL have port out_valid, output, 1 bit: out_data and fill_count are valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result this cycle.
REQ-012 SHALL have port out_data, output, WIDTH bits: filled word.
REQ-013 SHALL have port fill_count, output, clog2(WIDTH+1) bits: number of bits changed from 0 to 1.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL fill every zero run bounded by a 1 on both sides whose length is at most the effective gap_len; a run with length 1 turns 101 into 111.
REQ-016 SHALL never fill leading zero runs (no 1 above them) or trailing zero runs (no 1 below them).
REQ-017 SHALL treat gap_len = 0 as pass-through: out_data equals in_data and fill_count is 0.
REQ-018 SHALL clamp gap_len values above MAX_GAP to MAX_GAP.
REQ-019 SHALL implement the FSM as follows:
- IDLE: in_ready=1; on in_valid, latch in_data and gap_len, set index=WIDTH-1, go to SCAN.
- SCAN: examine one bit per cycle, MSB first; on index 0, go to DONE.
- DONE: out_valid=1; on out_ready, go to IDLE.
REQ-020 SHALL, during SCAN, track seen_one, the zero-run length (saturating at MAX_GAP+1) and the run start index.
REQ-021 SHALL, on a 1 that follows a run with seen_one set and run length between 1 and the effective gap_len, set the whole run in the working word in that same cycle and add the run length to fill_count.
REQ-022 SHALL assert out_valid exactly WIDTH+1 cycles after the in_valid&in_ready cycle.
REQ-023 SHALL keep in_ready low outside IDLE, so there is no input overlap and no simultaneous accept/complete; throughput is one word per WIDTH+2 cycles at minimum.
REQ-024 SHALL hold out_data and fill_count stable while out_valid=1 and out_ready=0.
REQ-025 SHALL return to IDLE from DONE when out_valid&out_ready, and assert in_ready on the following cycle.

Reset
REQ-026 SHALL, on reset, put the FSM in IDLE and drive in_ready=1, out_valid=0, busy=0, out_data=0, fill_count=0, and clear seen_one and the run counter.
REQ-027 SHALL give reset priority over all handshakes; reset mid-SCAN or mid-DONE discards the word with no output produced.

Structure
REQ-028 SHALL place FSM state encodings (IDLE, SCAN, DONE) and width helper functions (GAP_W, count width) in a shared package, gap_fill_pkg.
REQ-029 SHALL contain one combinational sub-module, range_mask, which produces a WIDTH-bit mask of ones between a start index and an end index (inclusive) for the run fill.

Verification
REQ-030 SHALL verify: WIDTH=6, in_data=101001, gap_len=1 -> out_data=111001, fill_count=1, out_valid 7 cycles after accept.
REQ-031 SHALL verify: in_data=101001, gap_len=2 -> out_data=111111, fill_count=3; in_data=100001, gap_len=3 -> 100001, fill_count=0.
REQ-032 SHALL verify: in_data=010100, gap_len=1 -> 011100 (leading and trailing zeros untouched); gap_len=0 with in_data=101010 -> 101010, fill_count=0.
REQ-033 SHALL verify: out_ready held low 5 cycles in DONE -> out_data stable, in_ready=0 throughout, new in_valid ignored.
REQ-034 SHALL verify: reset asserted at SCAN cycle 3 -> next cycle in IDLE, out_valid=0, then a fresh word 10101x processes correctly.
REQ-035 SHALL verify: gap_len=3 with MAX_GAP=2, in_data=100010 -> clamped to 2, out_data=100010 (the gap of 3 is not filled).

Source files
------------

// File: rtl/gap_fill_pkg.sv
// Shared types and width helpers for the serial gap-fill block.
package gap_fill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the gap_len port: enough to hold 0..max_gap.
    function automatic int gap_w(input int max_gap);
        return $clog2(max_gap + 1);
    endfunction

    // Width of the fill counter: enough to hold 0..width.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    // Width of a bit index into a word of the given width.
    function automatic int idx_w(input int width);
        return $clog2(width);
    endfunction

    // Width of the zero-run counter, which saturates at max_gap+1.
    function automatic int run_w(input int max_gap);
        return $clog2(max_gap + 2);
    endfunction

endpackage

// File: rtl/gap_fill_serial_range_mask.sv
// Combinational mask generator: ones from lo up to hi inclusive.
module range_mask
    import gap_fill_pkg::*;
#(
    parameter int WIDTH = 6,
    localparam int IDX_W = idx_w(WIDTH)
) (
    input  logic [IDX_W-1:0] hi,
    input  logic [IDX_W-1:0] lo,
    output logic [WIDTH-1:0] mask
);

    // Each bit is set when its position lies inside [lo, hi].
    always_comb begin
        mask = '0;
        for (int j = 0; j < WIDTH; j++) begin
            mask[j] = (IDX_W'(j) >= lo) && (IDX_W'(j) <= hi);
        end
    end

endmodule

// File: rtl/gap_fill_serial.sv
// Serial gap filler: scans a word MSB first, one bit per cycle, and fills
// enclosed zero runs no longer than the requested gap length.
module gap_fill_serial
    import gap_fill_pkg::*;
#(
    parameter int WIDTH   = 6,
    parameter int MAX_GAP = 3,
    localparam int GAP_W  = gap_w(MAX_GAP),
    localparam int CNT_W  = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [GAP_W-1:0] gap_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] fill_count,
    output logic             busy
);

    localparam int IDX_W = idx_w(WIDTH);
    localparam int RUN_W = run_w(MAX_GAP);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] index;
    logic [WIDTH-1:0] work;
    logic [CNT_W-1:0] count;
    logic [GAP_W-1:0] gap_eff;
    logic [GAP_W-1:0] gap_clamped;
    logic             seen_one;
    logic [RUN_W-1:0] run_len;
    logic [IDX_W-1:0] run_start;
    logic [IDX_W-1:0] run_end;
    logic [WIDTH-1:0] fill_mask;
    logic             fill_now;

    // Gap lengths beyond what the run counter can judge are clamped.
    assign gap_clamped = (gap_len > GAP_W'(MAX_GAP)) ? GAP_W'(MAX_GAP) : gap_len;

    // A 1 closes the current run; fill it if it is enclosed and short enough.
    assign fill_now = (state == SCAN) && work[index] && seen_one &&
                      (run_len != '0) && (run_len <= RUN_W'(gap_eff));

    // The run occupies the bits just above the closing 1 up to its start.
    assign run_end = index + IDX_W'(1);

    range_mask #(
        .WIDTH(WIDTH)
    ) u_range_mask (
        .hi  (run_start),
        .lo  (run_end),
        .mask(fill_mask)
    );

    assign out_data   = work;
    assign fill_count = count;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (index == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch the word on accept, then walk it one bit per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            index     <= '0;
            work      <= '0;
            count     <= '0;
            gap_eff   <= '0;
            seen_one  <= 1'b0;
            run_len   <= '0;
            run_start <= '0;
        end else if (state == IDLE && in_valid) begin
            index     <= IDX_W'(WIDTH - 1);
            work      <= in_data;
            count     <= '0;
            gap_eff   <= gap_clamped;
            seen_one  <= 1'b0;
            run_len   <= '0;
            run_start <= '0;
        end else if (state == SCAN) begin
            if (index != '0) begin
                index <= index - IDX_W'(1);
            end
            if (work[index]) begin
                if (fill_now) begin
                    work  <= work | fill_mask;
                    count <= count + CNT_W'(run_len);
                end
                seen_one <= 1'b1;
                run_len  <= '0;
            end else begin
                if (run_len == '0) begin
                    run_start <= index;
                end
                if (run_len != RUN_W'(MAX_GAP + 1)) begin
                    run_len <= run_len + RUN_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gap_fill_serial.sv
// Directed bench for gap_fill_serial: one DUT at MAX_GAP=3 and a second at
// MAX_GAP=2 share all inputs so clamping can be observed side by side.
module tb_gap_fill_serial;

    localparam int WIDTH = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       out_ready;
    logic [5:0] in_data;
    logic [1:0] gap_len;

    logic       in_ready, out_valid, busy;
    logic [5:0] out_data;
    logic [2:0] fill_count;

    logic       in_ready2, out_valid2, busy2;
    logic [5:0] out_data2;
    logic [2:0] fill_count2;

    int n_compared   = 0;
    int n_mismatched = 0;
    int lat;
    bit early_valid;

    always #5 clk = ~clk;

    gap_fill_serial #(.WIDTH(WIDTH), .MAX_GAP(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .gap_len(gap_len), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .fill_count(fill_count),
        .busy(busy)
    );

    gap_fill_serial #(.WIDTH(WIDTH), .MAX_GAP(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .gap_len(gap_len), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .fill_count(fill_count2),
        .busy(busy2)
    );

    // Single comparison point: counts every check and reports failures.
    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Offer one word, then wait (bounded) for the result and check latency.
    task automatic applyStimulus(input string tag, input logic [5:0] data,
                                 input logic [1:0] gap);
        @(negedge clk);
        in_data  = data;
        gap_len  = gap;
        in_valid = 1'b1;
        checkValue({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkValue({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkValue({tag, "_latency"}, 32'(lat), 32'(WIDTH + 1));
    endtask

    // Check the presented result, consume it, and confirm return to IDLE.
    task automatic checkOutput(input string tag, input logic [5:0] exp_data,
                               input logic [2:0] exp_count);
        checkValue({tag, "_data"}, 32'(out_data), 32'(exp_data));
        checkValue({tag, "_count"}, 32'(fill_count), 32'(exp_count));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkValue({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        checkValue({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        gap_len   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkValue("rst_in_ready", 32'(in_ready), 32'd1);
        checkValue("rst_out_valid", 32'(out_valid), 32'd0);
        checkValue("rst_busy", 32'(busy), 32'd0);
        checkValue("rst_out_data", 32'(out_data), 32'd0);
        checkValue("rst_fill_count", 32'(fill_count), 32'd0);
        checkValue("rst_in_ready2", 32'(in_ready2), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] basic fills");
        applyStimulus("g1", 6'b101001, 2'd1);
        checkOutput("g1", 6'b111001, 3'd1);
        applyStimulus("g2", 6'b101001, 2'd2);
        checkOutput("g2", 6'b111111, 3'd3);
        applyStimulus("long_run", 6'b100001, 2'd3);
        checkOutput("long_run", 6'b100001, 3'd0);
        applyStimulus("edges", 6'b010100, 2'd1);
        checkOutput("edges", 6'b011100, 3'd1);
        applyStimulus("pass", 6'b101010, 2'd0);
        checkOutput("pass", 6'b101010, 3'd0);

        $display("[TB] clamping");
        applyStimulus("clamp_a", 6'b100010, 2'd3);
        checkValue("clamp_a_valid2", 32'(out_valid2), 32'd1);
        checkValue("clamp_a_data2", 32'(out_data2), 32'(6'b100010));
        checkValue("clamp_a_count2", 32'(fill_count2), 32'd0);
        checkOutput("clamp_a", 6'b111110, 3'd3);
        applyStimulus("clamp_b", 6'b100101, 2'd3);
        checkValue("clamp_b_data2", 32'(out_data2), 32'(6'b111111));
        checkValue("clamp_b_count2", 32'(fill_count2), 32'd3);
        checkOutput("clamp_b", 6'b111111, 3'd3);

        $display("[TB] backpressure in DONE");
        applyStimulus("hold", 6'b101001, 2'd2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 6'b000111;
            gap_len  = 2'd1;
            @(posedge clk);
            #1;
            checkValue("hold_data", 32'(out_data), 32'(6'b111111));
            checkValue("hold_count", 32'(fill_count), 32'd3);
            checkValue("hold_in_ready", 32'(in_ready), 32'd0);
            checkValue("hold_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("hold", 6'b111111, 3'd3);
        @(posedge clk);
        #1;
        checkValue("hold_not_accepted", 32'(busy), 32'd0);

        $display("[TB] reset during SCAN");
        @(negedge clk);
        in_data  = 6'b101001;
        gap_len  = 2'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkValue("mid_rst_in_ready", 32'(in_ready), 32'd1);
        checkValue("mid_rst_valid", 32'(out_valid), 32'd0);
        checkValue("mid_rst_busy", 32'(busy), 32'd0);
        checkValue("mid_rst_data", 32'(out_data), 32'd0);
        checkValue("mid_rst_count", 32'(fill_count), 32'd0);
        checkValue("mid_rst_busy2", 32'(busy2), 32'd0);
        reset = 1'b0;
        early_valid = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) early_valid = 1'b1;
        end
        checkValue("mid_rst_no_output", 32'(early_valid), 32'd0);
        applyStimulus("fresh", 6'b101010, 2'd1);
        checkOutput("fresh", 6'b111110, 3'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
